// File: rtl/conv3x3_seq_if.sv
// Bus between conv3x3_seq and its neighbours: upstream window handshake,
// column select / partial sum to the datapath, and the downstream result handshake.
interface conv3x3_seq_if #(
    parameter int SUM_W = 16,
    parameter int ACC_W = 18
);
    // Valid/ready: a transfer happens on a rising edge where valid & ready are both
    // high; valid never waits for ready, and the producer holds data while valid & !ready.
    logic             in_valid;
    logic             in_ready;
    logic             win_load;
    logic [1:0]       sel;
    logic [SUM_W-1:0] sum_in;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic [7:0]       pix_out;
    logic             sat;
    logic             busy;
    logic [2:0]       dbg_state;

    modport master (
        output in_valid, sum_in, out_ready,
        input  in_ready, win_load, sel, out_valid, acc_out, pix_out, sat, busy, dbg_state
    );

    modport slave (
        input  in_valid, sum_in, out_ready,
        output in_ready, win_load, sel, out_valid, acc_out, pix_out, sat, busy, dbg_state
    );
endinterface

// File: rtl/conv3x3_seq.sv
// Steps the 3x3 datapath through columns 0..2, sums the three partial sums,
// then shifts and saturates the total to an 8-bit pixel.
module conv3x3_seq #(
    parameter int SUM_W = 16,
    parameter int ACC_W = 18,
    parameter int SHIFT = 8
) (
    input  logic              clk,
    input  logic              rst,
    conv3x3_seq_if.slave      bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAC0 = 3'd1,
        S_MAC1 = 3'd2,
        S_MAC2 = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [ACC_W-1:0] r_acc;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_acc_out;
    logic [7:0]       r_pix;
    logic             r_sat;

    logic             w_in_ready;
    logic             w_win_load;
    logic [1:0]       w_sel;
    logic             w_busy;
    logic [ACC_W-1:0] w_sum_ext;
    logic [ACC_W-1:0] w_acc_sum;
    logic [ACC_W-1:0] w_shifted;
    logic             w_over;

    // ACC_W >= SUM_W+2 keeps three partial sums from wrapping.
    assign w_sum_ext = {{(ACC_W-SUM_W){1'b0}}, bus.sum_in};
    assign w_acc_sum = r_acc + w_sum_ext;
    assign w_shifted = w_acc_sum >> SHIFT;
    assign w_over    = (w_shifted > ACC_W'(255));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_win_load) w_next_state = S_MAC0;
            S_MAC0: w_next_state = S_MAC1;
            S_MAC1: w_next_state = S_MAC2;
            S_MAC2: w_next_state = S_DONE;
            S_DONE: begin
                if (w_win_load)         w_next_state = S_MAC0;
                else if (bus.out_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_sel      = 2'd0;
        w_busy     = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
            end
            S_MAC0: w_sel = 2'd0;
            S_MAC1: w_sel = 2'd1;
            S_MAC2: w_sel = 2'd2;
            S_DONE: w_in_ready = bus.out_ready;
            default: w_busy = 1'b0;
        endcase
        w_win_load = bus.in_valid & w_in_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_acc_out   <= '0;
            r_pix       <= '0;
            r_sat       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_load) r_acc <= '0;
                end
                S_MAC0: r_acc <= w_sum_ext;
                S_MAC1: r_acc <= w_acc_sum;
                S_MAC2: begin
                    r_acc       <= w_acc_sum;
                    r_out_valid <= 1'b1;
                    r_acc_out   <= w_acc_sum;
                    r_pix       <= w_over ? 8'hFF : w_shifted[7:0];
                    r_sat       <= w_over;
                end
                S_DONE: begin
                    // Result fields stay put until overwritten by the next MAC2.
                    if (bus.out_ready) r_out_valid <= 1'b0;
                    if (w_win_load)    r_acc       <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.win_load  = w_win_load;
    assign bus.sel       = w_sel;
    assign bus.busy      = w_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.acc_out   = r_acc_out;
    assign bus.pix_out   = r_pix;
    assign bus.sat       = r_sat;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_conv3x3_seq.sv
// Directed bench for conv3x3_seq: a vector table of windows plus hand-written
// backpressure, back-to-back, mid-operation reset and in_valid-toggle sequences.
module tb_conv3x3_seq;

    localparam int SUM_W = 16;
    localparam int ACC_W = 18;
    localparam int SHIFT = 8;

    logic clk;
    logic rst;

    conv3x3_seq_if #(.SUM_W(SUM_W), .ACC_W(ACC_W)) bus ();

    conv3x3_seq #(.SUM_W(SUM_W), .ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int wl_cnt = 0;

    // Upstream model: windows queued as {s0,s1,s2}, captured on win_load.
    logic [47:0]        up_q[$];
    logic [SUM_W-1:0]   cur_s0, cur_s1, cur_s2;
    // Scoreboard entries: {acc_out, pix_out, sat}.
    logic [ACC_W+8:0]   exp_q[$];

    initial begin
        cur_s0 = '0;
        cur_s1 = '0;
        cur_s2 = '0;
    end

    always @(posedge clk) begin
        if (bus.win_load) begin
            wl_cnt <= wl_cnt + 1;
            if (up_q.size() > 0) begin
                cur_s0 <= up_q[0][47:32];
                cur_s1 <= up_q[0][31:16];
                cur_s2 <= up_q[0][15:0];
                void'(up_q.pop_front());
            end
        end
    end

    always @* begin
        case (bus.sel)
            2'd0:    bus.sum_in = cur_s0;
            2'd1:    bus.sum_in = cur_s1;
            2'd2:    bus.sum_in = cur_s2;
            default: bus.sum_in = '0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                chk("acc_out", 32'(bus.acc_out), 32'(exp_q[0][ACC_W+8:9]));
                chk("pix_out", 32'(bus.pix_out), 32'(exp_q[0][8:1]));
                chk("sat",     32'(bus.sat),     32'(exp_q[0][0]));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1, "timeout");
    end

    // Offer the queued window, then follow one pass through MAC0..DONE->IDLE.
    task automatic run_window(input bit toggle);
        int  base;
        bit  got;
        logic [5:0] sel_seq;
        base = wl_cnt;
        got  = 1'b0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.win_load) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        sel_seq[5:4] = bus.sel;
        bus.in_valid = toggle;
        #1 chk("busy_mac", 32'(bus.busy), 32'd1);
        @(negedge clk);
        sel_seq[3:2] = bus.sel;
        bus.in_valid = 1'b0;
        @(negedge clk);
        sel_seq[1:0] = bus.sel;
        bus.in_valid = toggle;
        chk("sel_seq", 32'(sel_seq), 32'(6'b00_01_10));
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 chk("out_valid_latency", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        #1 chk("idle_after", 32'({bus.out_valid, bus.busy}), 32'd0);
        chk("win_load_count", 32'(wl_cnt - base), 32'd1);
    endtask

    typedef struct {
        logic [SUM_W-1:0] s0, s1, s2;
        logic [ACC_W-1:0] acc;
        logic [7:0]       pix;
        logic             sat;
        bit               toggle;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int t0;
        int nload;
        int ov_cnt;
        int t_load [2];

        vecs[0] = '{16'd100,   16'd200,   16'd300,   18'd600,    8'd2,   1'b0, 1'b0};
        vecs[1] = '{16'd65535, 16'd65535, 16'd65535, 18'd196605, 8'd255, 1'b1, 1'b0};
        vecs[2] = '{16'd21845, 16'd21845, 16'd21845, 18'd65535,  8'd255, 1'b0, 1'b0};
        vecs[3] = '{16'd21846, 16'd21845, 16'd21847, 18'd65538,  8'd255, 1'b1, 1'b0};
        vecs[4] = '{16'd256,   16'd0,     16'd0,     18'd256,    8'd1,   1'b0, 1'b0};
        vecs[5] = '{16'd0,     16'd0,     16'd0,     18'd0,      8'd0,   1'b0, 1'b0};
        vecs[6] = '{16'd0,     16'd512,   16'd1024,  18'd1536,   8'd6,   1'b0, 1'b1};
        vecs[7] = '{16'd40000, 16'd1,     16'd30000, 18'd70001,  8'd255, 1'b1, 1'b1};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state",     32'(bus.dbg_state), 32'd0);
        chk("rst_sel",       32'(bus.sel),       32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_acc_out",   32'(bus.acc_out),   32'd0);
        chk("rst_pix_out",   32'(bus.pix_out),   32'd0);
        chk("rst_sat",       32'(bus.sat),       32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            up_q.push_back({vecs[i].s0, vecs[i].s1, vecs[i].s2});
            exp_q.push_back({vecs[i].acc, vecs[i].pix, vecs[i].sat});
            run_window(vecs[i].toggle);
        end

        // Backpressure: result held while out_ready is low, next window waits.
        up_q.push_back({16'd1000, 16'd2000, 16'd3000});
        exp_q.push_back({18'd6000, 8'd23, 1'b0});
        up_q.push_back({16'd7, 16'd8, 16'd9});
        exp_q.push_back({18'd24, 8'd0, 1'b0});
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        #1 chk("bp_accept", 32'(bus.win_load), 32'd1);
        repeat (4) @(negedge clk);
        t0 = wl_cnt;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_acc_out",   32'(bus.acc_out),   32'd6000);
            chk("bp_pix_out",   32'(bus.pix_out),   32'd23);
            chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
        end
        chk("bp_no_win_load", 32'(wl_cnt - t0), 32'd0);
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_release_win_load", 32'(bus.win_load), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 chk("bp_next_mac0", 32'({bus.busy, bus.out_valid, bus.sel}), 32'(4'b1000));
        repeat (5) @(negedge clk);
        #1 chk("bp_idle", 32'(bus.busy), 32'd0);

        // Back-to-back with in_valid and out_ready high.
        up_q.push_back({16'd10, 16'd20, 16'd30});
        exp_q.push_back({18'd60, 8'd0, 1'b0});
        up_q.push_back({16'd1, 16'd2, 16'd3});
        exp_q.push_back({18'd6, 8'd0, 1'b0});
        nload  = 0;
        ov_cnt = 0;
        t_load[0] = -1;
        t_load[1] = -1;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (nload == 2) bus.in_valid = 1'b0;
            #1;
            if (bus.win_load) begin
                if (nload < 2) t_load[nload] = c;
                nload++;
            end
            if (bus.out_valid) ov_cnt++;
        end
        chk("b2b_loads",        32'(nload),                 32'd2);
        chk("b2b_load_period",  32'(t_load[1] - t_load[0]), 32'd4);
        chk("b2b_valid_cycles", 32'(ov_cnt),                32'd2);

        // Asynchronous reset while in MAC1 with a window pending.
        up_q.push_back({16'd50, 16'd50, 16'd50});
        @(negedge clk);
        bus.in_valid = 1'b1;
        #1 chk("rst_mid_accept", 32'(bus.win_load), 32'd1);
        repeat (2) @(negedge clk);
        #2 chk("rst_mid_pre_sel", 32'(bus.sel), 32'd1);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_mid_sel",       32'(bus.sel),       32'd0);
        chk("rst_mid_busy",      32'(bus.busy),      32'd0);
        chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        up_q.push_back({16'd5, 16'd5, 16'd5});
        exp_q.push_back({18'd15, 8'd0, 1'b0});
        run_window(1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
